// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus limit, wrap/saturate mode,
// parallel load and terminal-count / overflow / underflow flags.
module updown_counter_param #(
    parameter int WIDTH     = 8,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_top;
    logic             at_zero;

    // at_top uses >= so an out-of-range loaded value is treated as the boundary
    assign at_top  = (count_q >= limit);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (up_down) begin
                if (!at_top) begin
                    count_d = count_q + ONE;
                end else begin
                    count_d = SATURATE ? limit : '0;
                    ovf_d   = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - ONE;
                end else begin
                    count_d = SATURATE ? '0 : limit;
                    unf_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tc    = en & ~load & ~rst & (up_down ? at_top : at_zero);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: wrap and saturate instances vs a reference model,
// plus a two-stage cascade counted through 256 steps.
module tb_updown_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load, en, up_down;
    logic [3:0] load_val, limit;
    logic [3:0] cnt_w, cnt_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;

    logic       c_rst, c_en;
    logic [3:0] c1_cnt, c2_cnt;
    logic       c1_tc, c2_tc, c1_ovf, c2_ovf, c1_unf, c2_unf;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] c;
        logic       o;
        logic       u;
    } exp_t;

    exp_t       q_w[$];
    exp_t       q_s[$];
    logic [3:0] m_w, m_s;

    updown_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .limit(limit), .count(cnt_w), .tc(tc_w),
        .ovf(ovf_w), .unf(unf_w)
    );

    updown_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(3)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .limit(limit), .count(cnt_s), .tc(tc_s),
        .ovf(ovf_s), .unf(unf_s)
    );

    updown_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(0)) u_c1 (
        .clk(clk), .rst(c_rst), .en(c_en), .up_down(1'b1), .load(1'b0),
        .load_val(4'd0), .limit(4'd15), .count(c1_cnt), .tc(c1_tc),
        .ovf(c1_ovf), .unf(c1_unf)
    );

    updown_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(0)) u_c2 (
        .clk(clk), .rst(c_rst), .en(c1_tc), .up_down(1'b1), .load(1'b0),
        .load_val(4'd0), .limit(4'd15), .count(c2_cnt), .tc(c2_tc),
        .ovf(c2_ovf), .unf(c2_unf)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic mtc(input logic [3:0] c);
        return en & ~load & ~rst & (up_down ? (c >= limit) : (c == 4'd0));
    endfunction

    function automatic exp_t nxt(input logic [3:0] c, input bit sat,
                                 input logic [3:0] rv);
        exp_t e;
        e = '{c: c, o: 1'b0, u: 1'b0};
        if (rst) begin
            e.c = rv;
        end else if (load) begin
            e.c = load_val;
        end else if (en && up_down) begin
            if (c < limit) e.c = c + 4'd1;
            else begin
                e.c = sat ? limit : 4'd0;
                e.o = 1'b1;
            end
        end else if (en) begin
            if (c > 4'd0) e.c = c - 4'd1;
            else begin
                e.c = sat ? 4'd0 : limit;
                e.u = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic l, input logic e,
                        input logic ud, input logic [3:0] lv,
                        input logic [3:0] lim);
        exp_t ew, es;
        rst = r; load = l; en = e; up_down = ud;
        load_val = lv; limit = lim;
        #1;
        chk("tc_wrap", {7'd0, tc_w}, {7'd0, mtc(m_w)});
        chk("tc_sat", {7'd0, tc_s}, {7'd0, mtc(m_s)});
        ew = nxt(m_w, 1'b0, 4'd0);
        es = nxt(m_s, 1'b1, 4'd3);
        q_w.push_back(ew);
        q_s.push_back(es);
        m_w = ew.c;
        m_s = es.c;
        @(posedge clk);
        @(negedge clk);
        if (q_w.size() == 0 || q_s.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            ew = q_w.pop_front();
            es = q_s.pop_front();
            chk("cnt_wrap", {4'd0, cnt_w}, {4'd0, ew.c});
            chk("ovf_wrap", {7'd0, ovf_w}, {7'd0, ew.o});
            chk("unf_wrap", {7'd0, unf_w}, {7'd0, ew.u});
            chk("cnt_sat", {4'd0, cnt_s}, {4'd0, es.c});
            chk("ovf_sat", {7'd0, ovf_s}, {7'd0, es.o});
            chk("unf_sat", {7'd0, unf_s}, {7'd0, es.u});
        end
    endtask

    initial begin
        logic [7:0] cexp;
        rst = 1'b1; load = 1'b0; en = 1'b0; up_down = 1'b1;
        load_val = '0; limit = 4'd15;
        m_w = '0; m_s = '0;
        c_rst = 1'b1; c_en = 1'b0;
        @(negedge clk);

        // reset with load and en also asserted
        step(1, 1, 1, 1, 4'd7, 4'd15);
        chk("rst_wrap", {4'd0, cnt_w}, 8'd0);
        chk("rst_sat", {4'd0, cnt_s}, 8'd3);

        // count up full range and wrap
        for (int i = 0; i < 17; i++) step(0, 0, 1, 1, 4'd0, 4'd15);

        // modulus wrap down
        step(0, 1, 0, 0, 4'd0, 4'd9);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'd0, 4'd9);
        chk("wrapdn_cnt", {4'd0, cnt_w}, 8'd7);

        // saturation region: up 8, down 8 with limit 5
        step(0, 1, 0, 1, 4'd0, 4'd5);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 4'd0, 4'd5);
        chk("sat_top", {4'd0, cnt_s}, 8'd5);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 4'd0, 4'd5);
        chk("sat_bot", {4'd0, cnt_s}, 8'd0);

        // load beats enable
        step(0, 1, 1, 1, 4'd12, 4'd15);
        chk("load_cnt", {4'd0, cnt_w}, 8'd12);

        // out of range: load 14, limit 9
        step(0, 1, 0, 1, 4'd14, 4'd9);
        step(0, 0, 1, 1, 4'd0, 4'd9);
        chk("oor_up_w", {4'd0, cnt_w}, 8'd0);
        chk("oor_up_s", {4'd0, cnt_s}, 8'd9);
        step(0, 1, 0, 1, 4'd14, 4'd9);
        step(0, 0, 1, 0, 4'd0, 4'd9);
        chk("oor_dn", {4'd0, cnt_w}, 8'd13);

        // limit 0 pins count at 0
        step(0, 1, 0, 1, 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 4'd0, 4'd0);

        // hold
        step(0, 1, 0, 1, 4'd6, 4'd9);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 4'd0, 4'd9);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // cascade: two 4-bit stages form an 8-bit counter
        @(posedge clk);
        @(negedge clk);
        c_rst = 1'b0;
        c_en  = 1'b1;
        cexp  = 8'd0;
        chk("casc_rst", {c2_cnt, c1_cnt}, cexp);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            @(negedge clk);
            cexp = cexp + 8'd1;
            chk("casc_cnt", {c2_cnt, c1_cnt}, cexp);
        end
        chk("casc_wrap", {c2_cnt, c1_cnt}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
